// File: rtl/melody_seq_if.sv
// Handshake bundle between a melody sequencer and its controller / tone generator.
// Carries play control (start/stop), the note handshake (code/valid/ack) and status.
// The slave modport is the sequencer side; the master modport is the driving side.
interface melody_seq_if;
  logic       start;
  logic       stop;
  logic       note_ack;
  logic [2:0] note_code;
  logic       note_valid;
  logic       busy;
  logic       done;

  modport slave (
    input  start,
    input  stop,
    input  note_ack,
    output note_code,
    output note_valid,
    output busy,
    output done
  );

  modport master (
    output start,
    output stop,
    output note_ack,
    input  note_code,
    input  note_valid,
    input  busy,
    input  done
  );
endinterface

// File: rtl/melody_seq.sv
// Melody sequencer: walks a constant song table, presents each note until acked, then holds it for beats*BEAT_CYCLES.
// Latency: start -> note_valid two cycles later; ack -> next note_valid after beats*BEAT_CYCLES+2 cycles.
// Backpressure: a note stays presented (code/valid stable) until note_ack; macro MELODY_SEQ_LOOP_EN replays the song endlessly.
module melody_seq #(
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned ROM_DEPTH   = 16
) (
  input  logic         clk,
  input  logic         rst,
  melody_seq_if.slave  bus
);

  localparam int IDX_W = $clog2(ROM_DEPTH);
  localparam int CNT_W = 27;
  localparam logic [CNT_W-1:0] BEAT_LEN = CNT_W'(BEAT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);
  localparam logic [IDX_W-1:0] SONG_LEN = IDX_W'(8);

  // Song entries {note, beats}; every index past the table reads as the end marker (beats = 0).
  localparam logic [5:0] SONG [8] = '{
    {3'd1, 3'd1}, {3'd2, 3'd1}, {3'd3, 3'd1}, {3'd4, 3'd1},
    {3'd5, 3'd1}, {3'd6, 3'd1}, {3'd7, 3'd1}, {3'd0, 3'd2}
  };

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PRESENT = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [2:0]       beats_q, beats_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] note_code_q, note_code_d;
  logic       note_valid_q, note_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [5:0]       rom_dat;
  logic [2:0]       rom_note;
  logic [2:0]       rom_beats;
  logic             rom_end;
  logic [CNT_W-1:0] hold_len;
  logic             hold_last;

  // Song table lookup for the current index.
  always_comb begin
    rom_dat = 6'd0;
    if (index_q < SONG_LEN) rom_dat = SONG[index_q[2:0]];
  end

  assign rom_note  = rom_dat[5:3];
  assign rom_beats = rom_dat[2:0];
  assign rom_end   = (rom_beats == 3'd0);

  // Hold length is at most 7 * 2^24, which fits the 27-bit counter without overflow.
  assign hold_len  = CNT_W'(beats_q) * BEAT_LEN;
  assign hold_last = (cnt_q == hold_len - CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; stop outside IDLE overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && bus.stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (bus.start && !bus.stop) state_d = S_LOAD;
`ifdef MELODY_SEQ_LOOP_EN
        S_LOAD:    state_d = rom_end ? S_LOAD : S_PRESENT;
`else
        S_LOAD:    state_d = rom_end ? S_DONE : S_PRESENT;
`endif
        S_PRESENT: if (bus.note_ack) state_d = S_HOLD;
        S_HOLD:    if (hold_last) state_d = S_LOAD;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: song index, latched beat count and beat counter.
  always_comb begin
    index_d = index_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        if (!rom_end) beats_d = rom_beats;
`ifdef MELODY_SEQ_LOOP_EN
        else          index_d = '0;
`endif
      end
      S_PRESENT: cnt_d = '0;
      S_HOLD: begin
        if (hold_last) begin
          cnt_d   = '0;
          index_d = (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    // Any return to IDLE (stop, song end) rewinds to the first note.
    if (state_d == S_IDLE) begin
      index_d = '0;
      cnt_d   = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_q <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
    end else begin
      index_q <= index_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output next values, derived from the upcoming state so the outputs are plain flops.
  always_comb begin
    note_code_d = note_code_q;
    if (state_d == S_IDLE || state_d == S_DONE) note_code_d = 3'd0;
    else if (state_q == S_LOAD && state_d == S_PRESENT) note_code_d = rom_note;
    note_valid_d = (state_d == S_PRESENT);
    busy_d       = (state_d != S_IDLE);
    // LOAD -> LOAD only happens on the end marker in loop mode; it flags the end of a pass.
    done_d       = (state_d == S_DONE) || (state_q == S_LOAD && state_d == S_LOAD);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      note_code_q  <= 3'd0;
      note_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      note_code_q  <= note_code_d;
      note_valid_q <= note_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.note_code  = note_code_q;
  assign bus.note_valid = note_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_melody_seq.sv
// Directed bench for melody_seq with BEAT_CYCLES=4: per-cycle vector table plus hand-written reset sequences.
module tb_melody_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  melody_seq_if bus();

  melody_seq #(.BEAT_CYCLES(4), .ROM_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One record per clock: inputs driven for the cycle, outputs required after the following edge.
  typedef struct {
    logic       start;
    logic       stop;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input logic s, input logic p, input logic a,
                              input logic [2:0] c, input logic v, input logic b, input logic d);
    vec_t t;
    t.start = s; t.stop = p; t.ack = a;
    t.code = c; t.valid = v; t.busy = b; t.done = d;
    vecs.push_back(t);
  endfunction

  task automatic drive(input logic s, input logic p, input logic a);
    bus.start    = s;
    bus.stop     = p;
    bus.note_ack = a;
  endtask

  task automatic check(input string name, input logic [2:0] c, input logic v,
                       input logic b, input logic d);
    n_vec++;
    if ({bus.note_code, bus.note_valid, bus.busy, bus.done} !== {c, v, b, d}) begin
      n_err++;
      $display("FAIL %s: got code=%0d valid=%b busy=%b done=%b, want code=%0d valid=%b busy=%b done=%b",
               name, bus.note_code, bus.note_valid, bus.busy, bus.done, c, v, b, d);
    end
  endtask

  task automatic cycle(input string name, input logic s, input logic p, input logic a,
                       input logic [2:0] c, input logic v, input logic b, input logic d);
    @(negedge clk);
    drive(s, p, a);
    @(posedge clk);
    #1;
    check(name, c, v, b, d);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #1;
    check("reset_immediate", 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // start together with stop in IDLE is ignored
    add(1, 1, 0, 3'd0, 0, 0, 0);
    add(0, 0, 0, 3'd0, 0, 0, 0);

    // full song with ack tied high; a stray start in note 3's HOLD must not disturb it
    add(1, 0, 1, 3'd0, 0, 1, 0);
    for (int n = 1; n <= 7; n++) begin
      add(0, 0, 1, 3'(n), 1, 1, 0);
      for (int k = 0; k < 5; k++)
        add((n == 3 && k == 1) ? 1'b1 : 1'b0, 0, 1, 3'(n), 0, 1, 0);
    end
    add(0, 0, 1, 3'd0, 1, 1, 0);
    for (int k = 0; k < 9; k++) add(0, 0, 1, 3'd0, 0, 1, 0);
`ifdef MELODY_SEQ_LOOP_EN
    add(0, 0, 1, 3'd0, 0, 1, 1);
    add(0, 0, 1, 3'd1, 1, 1, 0);
    add(0, 1, 0, 3'd0, 0, 0, 0);
    add(0, 0, 0, 3'd0, 0, 0, 0);
`else
    add(0, 0, 1, 3'd0, 0, 1, 1);
    add(0, 0, 1, 3'd0, 0, 0, 0);
    add(0, 0, 0, 3'd0, 0, 0, 0);
`endif

    // ack withheld: Do stays presented, then Ri six cycles after the ack
    add(1, 0, 0, 3'd0, 0, 1, 0);
    for (int k = 0; k < 21; k++) add(0, 0, 0, 3'd1, 1, 1, 0);
    add(0, 0, 1, 3'd1, 0, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 3'd1, 0, 1, 0);
    add(0, 0, 0, 3'd2, 1, 1, 0);

    // stop in HOLD of note 3, then replay from note 1 and stop (with ack) in PRESENT
    add(0, 0, 1, 3'd2, 0, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 3'd2, 0, 1, 0);
    add(0, 0, 0, 3'd3, 1, 1, 0);
    add(0, 0, 1, 3'd3, 0, 1, 0);
    add(0, 0, 0, 3'd3, 0, 1, 0);
    add(0, 1, 0, 3'd0, 0, 0, 0);
    add(0, 0, 0, 3'd0, 0, 0, 0);
    add(1, 0, 0, 3'd0, 0, 1, 0);
    add(0, 0, 0, 3'd1, 1, 1, 0);
    add(0, 1, 1, 3'd0, 0, 0, 0);
    add(0, 0, 0, 3'd0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++)
      cycle($sformatf("vec%0d", i), vecs[i].start, vecs[i].stop, vecs[i].ack,
            vecs[i].code, vecs[i].valid, vecs[i].busy, vecs[i].done);

    // asynchronous reset while a note is presented
    cycle("arst_start", 1, 0, 0, 3'd0, 0, 1, 0);
    cycle("arst_present", 0, 0, 0, 3'd1, 1, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_outputs_before_edge", 3'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("arst_held_over_edge", 3'd0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("arst_release_idle", 3'd0, 0, 0, 0);
    cycle("arst_restart_load", 1, 0, 0, 3'd0, 0, 1, 0);
    cycle("arst_restart_note1", 0, 0, 0, 3'd1, 1, 1, 0);
    cycle("arst_final_stop", 0, 1, 0, 3'd0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
